// File: rtl/bit_shift_engine_pkg.sv
// Shared constants for the bit shift engine: FSM encodings and default sizing.
package bit_shift_engine_pkg;

    localparam int unsigned DEFAULT_WIDTH = 9;
    localparam int unsigned DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

endpackage

// File: rtl/bit_shift_engine_if.sv
// Control/data bundle between a requester (master) and the shift engine (slave).
interface bit_shift_engine_if
    import bit_shift_engine_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = DEFAULT_CNT_W
);
    logic [WIDTH-1:0] in_i;
    logic             load_i;
    logic             start_i;
    logic [CNT_W-1:0] count_i;
    logic             msb_first_i;
    logic             serial_in_i;
    logic             step_i;
    logic [WIDTH-1:0] out_o;
    logic             serial_out_o;
    logic             busy_o;
    logic             done_o;

    modport master (
        output in_i, load_i, start_i, count_i, msb_first_i, serial_in_i, step_i,
        input  out_o, serial_out_o, busy_o, done_o
    );

    modport slave (
        input  in_i, load_i, start_i, count_i, msb_first_i, serial_in_i, step_i,
        output out_o, serial_out_o, busy_o, done_o
    );
endinterface

// File: rtl/bit_shift_engine.sv
// Parallel-load shift register that shifts a requested number of bits on step ticks,
// in either direction, with a busy flag and a one-cycle done pulse.
module bit_shift_engine
    import bit_shift_engine_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    bit_shift_engine_if.slave  bus
);

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             dir_q, dir_d;
    logic             done_q, done_d;
    logic             eff_dir;

    // State register; reset forces everything back to an idle, cleared engine.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; a start with count 0 completes immediately without shifting.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.load_i) begin
                    out_d = bus.in_i;
                end
                if (bus.start_i) begin
                    if (bus.count_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        dir_d   = bus.msb_first_i;
                        rem_d   = (bus.count_i > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : bus.count_i;
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                if (bus.step_i) begin
                    if (dir_q) begin
                        out_d = {out_q[WIDTH-2:0], bus.serial_in_i};
                    end else begin
                        out_d = {bus.serial_in_i, out_q[WIDTH-1:1]};
                    end
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Exit bit follows the latched direction while shifting, the requested one otherwise.
    assign eff_dir = (state_q == ST_SHIFT) ? dir_q : bus.msb_first_i;

    assign bus.out_o        = out_q;
    assign bus.busy_o       = (state_q == ST_SHIFT);
    assign bus.done_o       = done_q;
    assign bus.serial_out_o = eff_dir ? out_q[WIDTH-1] : out_q[0];

endmodule

// File: doc/bit_shift_engine.md
BIT_SHIFT_ENGINE -- requirements
Module: bit_shift_engine

Interface
REQ-001 Parameter WIDTH, default 9: data register width in bits, legal range 2..32.
REQ-002 Parameter CNT_W, default 4: shift-count width, SHALL equal clog2(WIDTH+1).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in  input  WIDTH  parallel load data.
REQ-006 load  input  1  parallel load request; honoured only in IDLE.
REQ-007 start  input  1  begin shift operation; honoured only in IDLE.
REQ-008 count  input  CNT_W  number of shifts requested; sampled with start.
REQ-009 msb_first  input  1  direction: 1 shifts left (MSB out), 0 shifts right (LSB out); sampled with start.
REQ-010 serial_in  input  1  bit inserted at the vacated end on each shift.
REQ-011 step  input  1  shift-enable tick, e.g. baud or SCK tick; any duty cycle.
REQ-012 out  output  WIDTH  registered data register.
REQ-013 serial_out  output  1  bit currently presented at the exit end.
REQ-014 busy  output  1  high while in SHIFT.
REQ-015 done  output  1  one-cycle pulse on completion.

Function
REQ-016 Two states: IDLE and SHIFT; internal registers: remaining (CNT_W), dir (1).
REQ-017 In IDLE, load=1: out <= in on the next edge.
REQ-018 In IDLE, start=1 with count>0: dir <= msb_first, remaining <= min(count, WIDTH), state <= SHIFT.
REQ-019 In IDLE, start=1 with count=0: stay in IDLE, out unchanged, done=1 for the following cycle.
REQ-020 load and start together in IDLE: both take effect, out <= in and SHIFT entered on the same edge.
REQ-021 step in the start-accept cycle is ignored; shifting begins on the first step seen while busy=1.
REQ-022 In SHIFT with step=1: dir=0 gives out <= {serial_in, out[WIDTH-1:1]}; dir=1 gives out <= {out[WIDTH-2:0], serial_in}; remaining decrements by 1.
REQ-023 In SHIFT with step=0: out and remaining hold.
REQ-024 When a step brings remaining to 0: state <= IDLE and done=1 for exactly the next cycle; busy falls on the same edge.
REQ-025 load and start SHALL be ignored while busy=1.
REQ-026 serial_out is combinational: out[0] when the effective direction is 0, out[WIDTH-1] when it is 1; effective direction is dir when busy, else msb_first.
REQ-027 Shift latency: exactly N step pulses for N = min(count, WIDTH); no extra cycles apart from the done pulse.

Reset
REQ-028 reset=1 SHALL immediately force out=0, state=IDLE, remaining=0, dir=0, busy=0, done=0, including mid-operation.
REQ-029 The first edge after reset deassertion SHALL honour load/start as in IDLE.

Structure
REQ-030 State encodings (IDLE=0, SHIFT=1) and the default WIDTH SHALL live in the shared include package.
REQ-031 The block is single-module; no sub-module.

Verification (WIDTH=9)
REQ-032 Load 9'h1A5, start count=9 msb_first=0, serial_in=0, step every cycle -> serial_out sequence 1,0,1,0,0,1,0,1,1; out=9'h000; done pulses once, 1 cycle after the 9th step.
REQ-033 Load 9'h000, start count=4 msb_first=1, serial_in=1 -> out=9'h00F after the 4th step; busy high for exactly 4 step-cycles.
REQ-034 step every 3rd cycle, count=3 -> out shifts only on step cycles; done follows the 3rd step; load=1 mid-shift leaves out unaltered.
REQ-035 start count=0 -> busy stays 0, out unchanged, done=1 on the next cycle only; start count=12 -> exactly 9 shifts.
REQ-036 Assert reset after 3 of 9 steps -> out=0, busy=0, done=0 without waiting for a clock edge; a subsequent load 9'h155 is honoured.
REQ-037 Random in/load/start/count/msb_first/serial_in/step for 1000 cycles, compared each cycle against a behavioural model.
